// File: rtl/loader_pkg.sv
// Shared constants, state encoding and length decode for the program loader.
package loader_pkg;

    localparam int unsigned ADDR_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned COUNT_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned FULL_COUNT  = 1 << ADDR_WIDTH;

    localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        DATA  = 3'd3,
        CHECK = 3'd4
    } loaderState_t;

    // A LEN byte of zero stands for a full-memory image.
    function automatic logic [COUNT_WIDTH-1:0] lenToCount(input logic [DATA_WIDTH-1:0] len);
        if (len == '0) begin
            return COUNT_WIDTH'(FULL_COUNT);
        end
        return COUNT_WIDTH'(len);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes a program image into instruction memory
// and holds the processor until a frame with a valid checksum has landed.
module prog_loader
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memDataWrite,
    output logic                  memWriteStrobe,
    output logic                  cpuHold,
    output logic                  done,
    output logic                  error
);

    loaderState_t             state;
    logic [ADDR_WIDTH-1:0]    ptr;
    logic [COUNT_WIDTH-1:0]   count;
    logic [DATA_WIDTH-1:0]    checksum;
    logic [DATA_WIDTH-1:0]    sumWithByte;
    logic                     accept;

    assign accept      = rxValid & rxReady;
    assign sumWithByte = checksum + rxData;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            count          <= '0;
            checksum       <= '0;
            rxReady        <= 1'b0;
            memAddr        <= '0;
            memDataWrite   <= '0;
            memWriteStrobe <= 1'b0;
            cpuHold        <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            rxReady        <= 1'b1;
            memWriteStrobe <= 1'b0;
            done           <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (rxData == SYNC_BYTE) begin
                            state   <= ADDR;
                            cpuHold <= 1'b1;
                            error   <= 1'b0;
                        end
                    end
                    ADDR: begin
                        ptr      <= ADDR_WIDTH'(rxData);
                        checksum <= rxData;
                        state    <= LEN;
                    end
                    LEN: begin
                        count    <= lenToCount(rxData);
                        checksum <= sumWithByte;
                        state    <= DATA;
                    end
                    DATA: begin
                        memAddr        <= ptr;
                        memDataWrite   <= rxData;
                        memWriteStrobe <= 1'b1;
                        ptr            <= ptr + ADDR_WIDTH'(1);
                        checksum       <= sumWithByte;
                        count          <= count - COUNT_WIDTH'(1);
                        if (count == COUNT_WIDTH'(1)) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        // Processor stays held on a bad image; memory is not rolled back.
                        if (sumWithByte == '0) begin
                            done    <= 1'b1;
                            cpuHold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as payload is
// driven and matched against each write strobe.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic [7:0] memAddr;
    logic [7:0] memDataWrite;
    logic       memWriteStrobe;
    logic       cpuHold;
    logic       done;
    logic       error;

    int         checks = 0;
    int         errors = 0;
    int         doneCount = 0;
    int         cycle = 0;
    logic       checkSpacing = 1'b0;
    logic [15:0] sb[$];
    logic [7:0]  payload[$];

    prog_loader dut (
        .clk           (clk),
        .reset         (reset),
        .rxData        (rxData),
        .rxValid       (rxValid),
        .rxReady       (rxReady),
        .memAddr       (memAddr),
        .memDataWrite  (memDataWrite),
        .memWriteStrobe(memWriteStrobe),
        .cpuHold       (cpuHold),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: scoreboard match, hold check and strobe spacing.
    logic [7:0] lastAddr = 8'h00;
    logic [7:0] lastData = 8'h00;
    logic       havePrev = 1'b0;
    int         prevCycle = 0;
    always @(negedge clk) begin
        if (!rxReady) begin
            lastAddr = 8'h00;
            lastData = 8'h00;
        end
        if (memWriteStrobe) begin
            if (sb.size() == 0) begin
                checkVal("unexpected_write", 32'(memWriteStrobe), 32'd0);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                checkVal("wr_addr", 32'(memAddr), 32'(exp[15:8]));
                checkVal("wr_data", 32'(memDataWrite), 32'(exp[7:0]));
            end
            if (checkSpacing && havePrev) checkVal("strobe_spacing", 32'(cycle - prevCycle), 32'd3);
            havePrev  = checkSpacing;
            prevCycle = cycle;
            lastAddr  = memAddr;
            lastData  = memDataWrite;
        end else begin
            if (!checkSpacing) havePrev = 1'b0;
            checkVal("hold_addr", 32'(memAddr), 32'(lastAddr));
            checkVal("hold_data", 32'(memDataWrite), 32'(lastData));
        end
        if (done) doneCount++;
    end

    // Called at a falling edge; the byte transfers on the next rising edge.
    task automatic sendByte(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        rxValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends SYNC, ADDR, LEN, the payload queue and CHK (computed if chkOverride < 0).
    task automatic sendFrame(input string name, input logic [7:0] addr, input int chkOverride, input int gap);
        logic [7:0] lenByte;
        logic [7:0] sum;
        logic [7:0] a;
        logic [7:0] chk;
        logic       good;
        int         doneBefore;
        doneBefore = doneCount;
        lenByte = 8'(payload.size());
        sum = addr + lenByte;
        a = addr;
        sendByte(8'hA5);
        checkVal({name, "_sync_hold"}, 32'(cpuHold), 32'd1);
        checkVal({name, "_sync_err"}, 32'(error), 32'd0);
        idle(gap);
        sendByte(addr);
        idle(gap);
        sendByte(lenByte);
        idle(gap);
        foreach (payload[i]) begin
            sb.push_back({a, payload[i]});
            a = a + 8'd1;
            sum = sum + payload[i];
            sendByte(payload[i]);
            idle(gap);
        end
        chk = (chkOverride < 0) ? 8'(8'd0 - sum) : 8'(chkOverride);
        good = ((sum + chk) == 8'h00);
        sendByte(chk);
        checkVal({name, "_done"}, 32'(done), 32'(good));
        checkVal({name, "_hold"}, 32'(cpuHold), 32'(!good));
        checkVal({name, "_error"}, 32'(error), 32'(!good));
        idle(1);
        checkVal({name, "_done_pulse"}, 32'(done), 32'd0);
        idle(2);
        checkVal({name, "_pending_writes"}, 32'(sb.size()), 32'd0);
        checkVal({name, "_done_count"}, 32'(doneCount - doneBefore), 32'(good));
        payload.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (3) @(negedge clk);
        checkVal("rst_ready", 32'(rxReady), 32'd0);
        checkVal("rst_strobe", 32'(memWriteStrobe), 32'd0);
        checkVal("rst_hold", 32'(cpuHold), 32'd1);
        checkVal("rst_done", 32'(done), 32'd0);
        checkVal("rst_error", 32'(error), 32'd0);
        checkVal("rst_addr", 32'(memAddr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkVal("ready_after_rst", 32'(rxReady), 32'd1);

        // Basic load: CHK works out to 0xD8.
        payload = '{8'h0C, 8'h0A, 8'hFF};
        sendFrame("basic", 8'h10, 8'hD8, 0);

        // Address wrap across 0xFF -> 0x00.
        payload = '{8'h11, 8'h22, 8'h33};
        sendFrame("wrap", 8'hFE, -1, 0);

        // Full 256-byte image with LEN = 0.
        for (int i = 0; i < 256; i++) payload.push_back(8'(i));
        sendFrame("full", 8'h00, 8'h80, 0);

        // Bad checksum: writes land, error set, processor held.
        payload = '{8'h0C, 8'h0A, 8'hFF};
        sendFrame("bad", 8'h10, 8'h00, 0);
        checkVal("bad_error_level", 32'(error), 32'd1);

        // A following good frame clears error on SYNC.
        payload = '{8'h01, 8'h02};
        sendFrame("recover", 8'h40, -1, 0);

        // Noise before sync is ignored; gapped frame with 0xA5 as payload data.
        sendByte(8'h00);
        sendByte(8'h5A);
        sendByte(8'hFF);
        idle(2);
        checkVal("noise_hold", 32'(cpuHold), 32'd0);
        checkVal("noise_queue", 32'(sb.size()), 32'd0);
        checkSpacing = 1'b1;
        payload = '{8'h0C, 8'hA5, 8'hFF, 8'hA5};
        sendFrame("gaps", 8'h80, -1, 2);
        checkSpacing = 1'b0;

        // Reset after the second payload byte of a three-byte frame.
        sendByte(8'hA5);
        sendByte(8'h20);
        sendByte(8'h03);
        sb.push_back({8'h20, 8'h11});
        sendByte(8'h11);
        sb.push_back({8'h21, 8'h22});
        sendByte(8'h22);
        reset   = 1'b1;
        rxValid = 1'b1;
        rxData  = 8'h33;
        @(negedge clk);
        checkVal("midrst_strobe", 32'(memWriteStrobe), 32'd0);
        checkVal("midrst_ready", 32'(rxReady), 32'd0);
        checkVal("midrst_hold", 32'(cpuHold), 32'd1);
        checkVal("midrst_addr", 32'(memAddr), 32'd0);
        checkVal("midrst_data", 32'(memDataWrite), 32'd0);
        checkVal("midrst_error", 32'(error), 32'd0);
        rxValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        checkVal("midrst_no_write", 32'(sb.size()), 32'd0);
        payload = '{8'h11, 8'h22, 8'h33};
        sendFrame("after_rst", 8'h20, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
